frame_strobe_sched: RTL and testbench
=====================================

# frame_strobe_sched

- Configuration-frame write scheduler that sequences the per-column `FrameStrobe` buses feeding fabric tiles.
- Accepts one frame-write request at a time over a valid/ready handshake, then drives `FrameData` for a programmable setup window.
- Pulses exactly one `FrameStrobe` bit for one cycle, holds the data for a programmable hold window, then reports completion.
- Sits between the bitstream loader and the column strobe chains (the strobe buffers inside each tile).

## Interface
Parameters:
- `NumColumns`, 10: fabric columns; each owns a `MaxFramesPerCol`-bit strobe slice.
- `MaxFramesPerCol`, 20: frames per column.
- `FrameBitsPerRow`, 32: frame data width.
- `SetupCycles`, 1: cycles data is stable before the strobe; legal range 1..15.
- `HoldCycles`, 1: cycles data is held after the strobe; legal range 1..15.

Ports:
- `UserCLK` in 1: single clock; all logic is rising-edge.
- `RST` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: scheduler can accept a request.
- `req_col` in `$clog2(NumColumns)`: target column.
- `req_frame` in 5: frame index within the column.
- `req_data` in `FrameBitsPerRow`: frame payload.
- `FrameData` out `FrameBitsPerRow`: data to the fabric rows.
- `FrameStrobe` out `NumColumns*MaxFramesPerCol`: column c, frame f is bit `c*MaxFramesPerCol+f`.
- `done` out 1: one-cycle pulse when a strobed write completes.
- `err` out 1: one-cycle pulse when a request was rejected.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD.
- `req_ready` = (state == IDLE), decoded from registered state.
- Accept occurs on a rising edge with `req_valid && req_ready`. The block latches `req_col`, `req_frame` and `req_data`.
- Valid accept (`req_col < NumColumns` and `req_frame < MaxFramesPerCol`):
  - Go to SETUP and load the counter with `SetupCycles-1`.
  - `FrameData` = latched data from that edge.
- Invalid accept:
  - Stay in IDLE; no strobe.
  - `err` = 1 for the next cycle; `FrameData` unchanged (0).
- SETUP: if counter == 0, go to STROBE; otherwise decrement.
- STROBE: lasts exactly one cycle, with exactly one `FrameStrobe` bit high. Then go to HOLD and load the counter with `HoldCycles-1`.
- HOLD: if counter == 0, go to IDLE, set `done` = 1 for one cycle and clear `FrameData` to 0; otherwise decrement.
- `FrameStrobe` is registered and glitch-free; it is all-zero in every state except STROBE.
- `req_*` inputs are ignored outside IDLE.
- Counter is 4 bits. Parameters outside 1..15 are an elaboration error via a generate-time check.

## Timing
- Reset values: state IDLE, `req_ready` 1, `FrameData` 0, `FrameStrobe` 0, `done` 0, `err` 0, counter 0.
- For an accept at edge E:
  - `FrameData` is valid from E.
  - `FrameStrobe` is high between edges E+S and E+S+1, where S = `SetupCycles`.
  - `done` is high between edges E+S+1+H and E+S+2+H, where H = `HoldCycles`.
  - `req_ready` returns high in the same cycle as `done`.
- Back-to-back throughput is one write per S+H+2 cycles. A request waiting with `req_valid` high is accepted at the edge that ends the `done` cycle.
- An invalid request occupies one cycle: `err` is high in the cycle after accept, and `req_ready` stays high.
- Reset asserted mid-operation: all outputs take their reset values immediately (asynchronously). A strobe in progress is truncated, and no `done` is issued.
- `done` and `err` never assert in the same cycle.

## Configuration
- Macro: `FRAME_STROBE_COUNT_EN`.
- Defined:
  - Adds output `strobe_count` [15:0], reset to 0.
  - It increments by one on every STROBE cycle and saturates at 16'hFFFF.
  - It is not incremented by rejected requests.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset, then idle for 5 cycles → `req_ready`=1; `FrameStrobe`=0, `FrameData`=0, `done`=0 and `err`=0 throughout.
- S=1, H=1: accept col 2, frame 3, data 32'hDEADBEEF at edge E → only bit 43 high between E+1 and E+2; `FrameData`=DEADBEEF from E to E+3; `done` high between E+3 and E+4.
- S=3, H=2: `req_valid` held high for two requests → second accepted at the edge ending the first `done` cycle; strobes 7 cycles apart.
- Accept frame 20 (≥ `MaxFramesPerCol`), then col 10 → `err` pulses one cycle each; no strobe bit ever high; `req_ready` stays 1.
- Assert `RST` during SETUP and again during STROBE → `FrameStrobe` returns to 0 without waiting for a clock; no `done`; next request completes normally.
- With `FRAME_STROBE_COUNT_EN`: 3 valid writes and 1 invalid write → `strobe_count`=3; preloaded at 16'hFFFF, one more write leaves it at 16'hFFFF.

Source files
------------

// File: rtl/frame_strobe_sched.sv
// ---------------------------------------------------------------------------
// frame_strobe_sched
//
// Configuration-frame write scheduler. Accepts one frame-write request at a
// time over a valid/ready handshake, presents the payload on FrameData for a
// programmable setup window, pulses exactly one FrameStrobe bit for a single
// cycle, holds the payload for a programmable hold window and then pulses
// done. Requests addressing a non-existent column or frame are rejected with
// a one-cycle err pulse and never reach the strobe chains.
//
// Parameters:
//   NumColumns      - fabric columns, each owning a MaxFramesPerCol-bit slice
//   MaxFramesPerCol - frames per column
//   FrameBitsPerRow - frame data width
//   SetupCycles     - cycles data is stable before the strobe (1..15)
//   HoldCycles      - cycles data is held after the strobe (1..15)
//
// Ports:
//   UserCLK      in   clock, rising edge
//   RST          in   asynchronous active-high reset
//   req_valid    in   request present
//   req_ready    out  scheduler idle and able to accept
//   req_col      in   target column
//   req_frame    in   frame index within the column
//   req_data     in   frame payload
//   FrameData    out  payload driven to the fabric rows
//   FrameStrobe  out  one-hot strobe, column c frame f is bit c*MaxFramesPerCol+f
//   done         out  one-cycle pulse when a strobed write completes
//   err          out  one-cycle pulse when a request was rejected
//   strobe_count out  (FRAME_STROBE_COUNT_EN only) saturating strobe counter
//
// Optional feature macro: FRAME_STROBE_COUNT_EN
//   When defined, adds the 16-bit saturating strobe_count output.
// ---------------------------------------------------------------------------
module frame_strobe_sched #(
  parameter int NumColumns      = 10,
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int SetupCycles     = 1,
  parameter int HoldCycles      = 1
) (
  input  logic                                  UserCLK,
  input  logic                                  RST,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic [$clog2(NumColumns)-1:0]         req_col,
  input  logic [4:0]                            req_frame,
  input  logic [FrameBitsPerRow-1:0]            req_data,
  output logic [FrameBitsPerRow-1:0]            FrameData,
  output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                  done,
  output logic                                  err
`ifdef FRAME_STROBE_COUNT_EN
  ,
  output logic [15:0]                           strobe_count
`endif
);

  localparam int ColW    = $clog2(NumColumns);
  localparam int StrobeW = NumColumns * MaxFramesPerCol;

  // Counters are reloaded with N-1 so that a window of N cycles ends on zero.
  localparam logic [3:0] SetupLoad = 4'(SetupCycles - 1);
  localparam logic [3:0] HoldLoad  = 4'(HoldCycles - 1);

  // Reject out-of-range timing parameters while elaborating.
  if ((SetupCycles < 1) || (SetupCycles > 15)) begin : g_setup_range_err
    $error("frame_strobe_sched: SetupCycles must be within 1..15");
  end
  if ((HoldCycles < 1) || (HoldCycles > 15)) begin : g_hold_range_err
    $error("frame_strobe_sched: HoldCycles must be within 1..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [3:0]             cnt_r;
  logic [3:0]             cnt_nxt_s;
  logic [ColW-1:0]        col_r;
  logic [ColW-1:0]        col_nxt_s;
  logic [4:0]             frame_r;
  logic [4:0]             frame_nxt_s;
  logic [FrameBitsPerRow-1:0] frame_data_r;
  logic [FrameBitsPerRow-1:0] frame_data_nxt_s;
  logic [StrobeW-1:0]     strobe_r;
  logic [StrobeW-1:0]     strobe_nxt_s;
  logic                   done_r;
  logic                   done_nxt_s;
  logic                   err_r;
  logic                   err_nxt_s;
  logic                   accept_s;
  logic                   req_ok_s;

  // One-hot decode of a (column, frame) pair into the flat strobe bus.
  function automatic logic [StrobeW-1:0] strobe_decode(
    input logic [ColW-1:0] col,
    input logic [4:0]      frame
  );
    logic [StrobeW-1:0] vec;
    vec = '0;
    for (int c = 0; c < NumColumns; c++) begin
      for (int f = 0; f < MaxFramesPerCol; f++) begin
        if ((int'(col) == c) && (int'(frame) == f)) begin
          vec[c*MaxFramesPerCol + f] = 1'b1;
        end else begin
          vec[c*MaxFramesPerCol + f] = 1'b0;
        end
      end
    end
    return vec;
  endfunction

  assign req_ready = (state_r == ST_IDLE);
  assign accept_s  = req_valid && req_ready;
  assign req_ok_s  = (int'(req_col) < NumColumns) && (int'(req_frame) < MaxFramesPerCol);

  assign FrameData   = frame_data_r;
  assign FrameStrobe = strobe_r;
  assign done        = done_r;
  assign err         = err_r;

  // FSM state register.
  always_ff @(posedge UserCLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; rejected requests leave the scheduler in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && req_ok_s) begin
          state_nxt_s = ST_SETUP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = ST_STROBE;
        end else begin
          state_nxt_s = ST_SETUP;
        end
      end
      ST_STROBE: begin
        state_nxt_s = ST_HOLD;
      end
      ST_HOLD: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM output logic: next values for the registered outputs, counter and
  // latched request. The strobe is computed one cycle early so that the
  // registered FrameStrobe is high exactly during STROBE.
  always_comb begin
    cnt_nxt_s        = cnt_r;
    col_nxt_s        = col_r;
    frame_nxt_s      = frame_r;
    frame_data_nxt_s = frame_data_r;
    strobe_nxt_s     = '0;
    done_nxt_s       = 1'b0;
    err_nxt_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          col_nxt_s   = req_col;
          frame_nxt_s = req_frame;
          if (req_ok_s) begin
            frame_data_nxt_s = req_data;
            cnt_nxt_s        = SetupLoad;
          end else begin
            err_nxt_s = 1'b1;
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_SETUP: begin
        if (cnt_r == 4'd0) begin
          strobe_nxt_s = strobe_decode(col_r, frame_r);
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_STROBE: begin
        cnt_nxt_s = HoldLoad;
      end
      ST_HOLD: begin
        if (cnt_r == 4'd0) begin
          done_nxt_s       = 1'b1;
          frame_data_nxt_s = '0;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      default: begin
        cnt_nxt_s        = 4'd0;
        frame_data_nxt_s = '0;
      end
    endcase
  end

  // Datapath and output registers; reset clears every output immediately.
  always_ff @(posedge UserCLK or posedge RST) begin
    if (RST) begin
      cnt_r        <= 4'd0;
      col_r        <= '0;
      frame_r      <= 5'd0;
      frame_data_r <= '0;
      strobe_r     <= '0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      cnt_r        <= cnt_nxt_s;
      col_r        <= col_nxt_s;
      frame_r      <= frame_nxt_s;
      frame_data_r <= frame_data_nxt_s;
      strobe_r     <= strobe_nxt_s;
      done_r       <= done_nxt_s;
      err_r        <= err_nxt_s;
    end
  end

`ifdef FRAME_STROBE_COUNT_EN
  logic [15:0] strobe_count_r;

  // Saturating count of completed STROBE cycles.
  always_ff @(posedge UserCLK or posedge RST) begin
    if (RST) begin
      strobe_count_r <= 16'd0;
    end else if ((state_r == ST_STROBE) && (strobe_count_r != 16'hFFFF)) begin
      strobe_count_r <= strobe_count_r + 16'd1;
    end else begin
      strobe_count_r <= strobe_count_r;
    end
  end

  assign strobe_count = strobe_count_r;
`endif

endmodule

// File: tb/tb_frame_strobe_sched.sv
`timescale 1ns/1ps
// Testbench for frame_strobe_sched. Two instances (S=1/H=1 and S=3/H=2)
// share one request stream; each is compared every cycle against a timeline
// model: an accept at edge E owns cycles E..E+S+H, strobes in cycle E+S and
// reports done in cycle E+S+1+H.
module tb_frame_strobe_sched;

  localparam int NCOL = 10;
  localparam int NFR  = 20;
  localparam int DW   = 32;
  localparam int SW   = NCOL * NFR;
  localparam int S_A  = 1;
  localparam int H_A  = 1;
  localparam int S_B  = 3;
  localparam int H_B  = 2;

  logic          clk_s = 1'b0;
  logic          rst_s;
  logic          req_valid_s;
  logic [3:0]    req_col_s;
  logic [4:0]    req_frame_s;
  logic [DW-1:0] req_data_s;

  logic          ready_a_s, ready_b_s;
  logic          done_a_s, done_b_s;
  logic          err_a_s, err_b_s;
  logic [DW-1:0] data_a_s, data_b_s;
  logic [SW-1:0] strobe_a_s, strobe_b_s;
`ifdef FRAME_STROBE_COUNT_EN
  logic [15:0]   cnt_a_s, cnt_b_s;
  logic [15:0]   exp_cnt[2];
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state, per instance.
  bit            wr_have[2];
  int            wr_edge[2];
  int            wr_idx[2];
  logic [DW-1:0] wr_data[2];
  bit            er_have[2];
  int            er_edge[2];
  int            strb_b_q[$];

  always #5 clk_s = ~clk_s;

  frame_strobe_sched #(
    .NumColumns(NCOL), .MaxFramesPerCol(NFR), .FrameBitsPerRow(DW),
    .SetupCycles(S_A), .HoldCycles(H_A)
  ) u_dut_a (
    .UserCLK(clk_s), .RST(rst_s), .req_valid(req_valid_s), .req_ready(ready_a_s),
    .req_col(req_col_s), .req_frame(req_frame_s), .req_data(req_data_s),
    .FrameData(data_a_s), .FrameStrobe(strobe_a_s), .done(done_a_s), .err(err_a_s)
`ifdef FRAME_STROBE_COUNT_EN
    , .strobe_count(cnt_a_s)
`endif
  );

  frame_strobe_sched #(
    .NumColumns(NCOL), .MaxFramesPerCol(NFR), .FrameBitsPerRow(DW),
    .SetupCycles(S_B), .HoldCycles(H_B)
  ) u_dut_b (
    .UserCLK(clk_s), .RST(rst_s), .req_valid(req_valid_s), .req_ready(ready_b_s),
    .req_col(req_col_s), .req_frame(req_frame_s), .req_data(req_data_s),
    .FrameData(data_b_s), .FrameStrobe(strobe_b_s), .done(done_b_s), .err(err_b_s)
`ifdef FRAME_STROBE_COUNT_EN
    , .strobe_count(cnt_b_s)
`endif
  );

  function automatic int s_of(input int k);
    return (k == 0) ? S_A : S_B;
  endfunction

  function automatic int h_of(input int k);
    return (k == 0) ? H_A : H_B;
  endfunction

  // Instance k is occupied during cycles E .. E+S+H of its latest write.
  function automatic bit m_busy(input int k, input int c);
    return wr_have[k] && (c >= wr_edge[k]) && (c < wr_edge[k] + s_of(k) + 1 + h_of(k));
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      wr_have[k] = 1'b0;
      er_have[k] = 1'b0;
`ifdef FRAME_STROBE_COUNT_EN
      exp_cnt[k] = 16'd0;
`endif
    end
  endtask

  task automatic chk_val(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", tag, cyc, obs, exp);
    end
  endtask

  // Compare every output of both instances with the model for cycle cyc.
  task automatic check_all();
    logic          rdy, dn, er;
    logic [DW-1:0] d;
    logic [SW-1:0] st, es;
    bit            busy;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        rdy = ready_a_s; dn = done_a_s; er = err_a_s; d = data_a_s; st = strobe_a_s;
      end else begin
        rdy = ready_b_s; dn = done_b_s; er = err_b_s; d = data_b_s; st = strobe_b_s;
      end
      busy = m_busy(k, cyc);
      es = '0;
      if (wr_have[k] && (cyc == wr_edge[k] + s_of(k))) es[wr_idx[k]] = 1'b1;
      chk_val($sformatf("ready_%0d", k), SW'(rdy), SW'(!busy));
      chk_val($sformatf("data_%0d", k), SW'(d), busy ? SW'(wr_data[k]) : '0);
      chk_val($sformatf("strobe_%0d", k), st, es);
      chk_val($sformatf("done_%0d", k), SW'(dn),
              SW'(wr_have[k] && (cyc == wr_edge[k] + s_of(k) + 1 + h_of(k))));
      chk_val($sformatf("err_%0d", k), SW'(er), SW'(er_have[k] && (cyc == er_edge[k])));
    end
`ifdef FRAME_STROBE_COUNT_EN
    chk_val("count_0", SW'(cnt_a_s), SW'(exp_cnt[0]));
    chk_val("count_1", SW'(cnt_b_s), SW'(exp_cnt[1]));
`endif
    if (strobe_b_s != '0) strb_b_q.push_back(cyc);
  endtask

  // Record accepts implied by the current inputs, advance one clock, check.
  task automatic step();
    for (int k = 0; k < 2; k++) begin
      if (!rst_s && req_valid_s && !m_busy(k, cyc)) begin
        if ((req_col_s < 4'd10) && (req_frame_s < 5'd20)) begin
          wr_have[k] = 1'b1;
          wr_edge[k] = cyc + 1;
          wr_idx[k]  = int'(req_col_s) * NFR + int'(req_frame_s);
          wr_data[k] = req_data_s;
        end else begin
          er_have[k] = 1'b1;
          er_edge[k] = cyc + 1;
        end
      end
    end
    @(posedge clk_s);
    cyc++;
`ifdef FRAME_STROBE_COUNT_EN
    for (int k = 0; k < 2; k++) begin
      if (!rst_s && wr_have[k] && (cyc == wr_edge[k] + s_of(k) + 1) && (exp_cnt[k] != 16'hFFFF))
        exp_cnt[k] = exp_cnt[k] + 16'd1;
    end
`endif
    @(negedge clk_s);
    check_all();
  endtask

  task automatic drain();
    int n = 0;
    req_valid_s = 1'b0;
    while ((m_busy(0, cyc) || m_busy(1, cyc)) && (n < 40)) begin
      step();
      n++;
    end
    step();
    chk_val("drain_ready_a", SW'(ready_a_s), SW'(1'b1));
    chk_val("drain_ready_b", SW'(ready_b_s), SW'(1'b1));
  endtask

  task automatic send(input logic [3:0] col, input logic [4:0] frame, input logic [DW-1:0] data);
    req_valid_s = 1'b1;
    req_col_s   = col;
    req_frame_s = frame;
    req_data_s  = data;
    step();
    req_valid_s = 1'b0;
  endtask

  // Hold the current request until instance b takes it (bounded).
  task automatic wait_accept_b();
    bit acc;
    for (int i = 0; i < 30; i++) begin
      acc = !m_busy(1, cyc);
      step();
      if (acc) break;
    end
  endtask

  // Assert reset between edges and confirm outputs clear without a clock.
  task automatic pulse_reset_mid(input string tag);
    #2 rst_s = 1'b1;
    #1;
    chk_val({tag, "_strobe_a"}, strobe_a_s, '0);
    chk_val({tag, "_strobe_b"}, strobe_b_s, '0);
    chk_val({tag, "_done_a"}, SW'(done_a_s), '0);
    chk_val({tag, "_done_b"}, SW'(done_b_s), '0);
    chk_val({tag, "_ready_b"}, SW'(ready_b_s), SW'(1'b1));
    chk_val({tag, "_data_b"}, SW'(data_b_s), '0);
    model_clear();
    req_valid_s = 1'b0;
    step();
    rst_s = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_s       = 1'b1;
    req_valid_s = 1'b0;
    req_col_s   = 4'd0;
    req_frame_s = 5'd0;
    req_data_s  = '0;
    model_clear();
    repeat (3) @(posedge clk_s);
    @(negedge clk_s);
    check_all();
    rst_s = 1'b0;

    // Idle after reset.
    repeat (5) step();

    // Single write on the S=1/H=1 instance: bit 2*20+3 = 43.
    send(4'd2, 5'd3, 32'hDEADBEEF);
    chk_val("a_data_E", SW'(data_a_s), SW'(32'hDEADBEEF));
    step();
    chk_val("a_bit43", SW'(strobe_a_s[43]), SW'(1'b1));
    step();
    step();
    chk_val("a_done_E3", SW'(done_a_s), SW'(1'b1));
    drain();

    // Back-to-back on the S=3/H=2 instance with req_valid held high.
    strb_b_q.delete();
    req_valid_s = 1'b1;
    req_col_s   = 4'd5;
    req_frame_s = 5'd19;
    req_data_s  = $urandom;
    wait_accept_b();
    req_col_s   = 4'd9;
    req_frame_s = 5'd0;
    req_data_s  = $urandom;
    wait_accept_b();
    drain();
    chk_val("b_strobe_count", SW'(strb_b_q.size()), SW'(2));
    chk_val("b_strobe_gap", SW'((strb_b_q.size() == 2) ? (strb_b_q[1] - strb_b_q[0]) : 0), SW'(7));

    // Rejected requests: frame out of range, then column out of range.
    send(4'd0, 5'd20, 32'h1111_2222);
    chk_val("a_err_frame20", SW'(err_a_s), SW'(1'b1));
    send(4'd10, 5'd0, 32'h3333_4444);
    chk_val("b_err_col10", SW'(err_b_s), SW'(1'b1));
    repeat (3) step();

    // Reset during SETUP.
    send(4'd1, 5'd7, 32'hA5A5_0001);
    pulse_reset_mid("rst_setup");
    repeat (2) step();

    // Reset during the S=3 instance's STROBE cycle.
    send(4'd3, 5'd11, 32'hA5A5_0002);
    step();
    step();
    step();
    chk_val("b_strobe_pre_rst", SW'(strobe_b_s != '0), SW'(1'b1));
    pulse_reset_mid("rst_strobe");
    repeat (2) step();
    send(4'd4, 5'd2, 32'hA5A5_0003);
    drain();

    // Randomized traffic, including out-of-range columns and frames.
    for (int i = 0; i < 400; i++) begin
      req_valid_s = ($urandom_range(0, 3) != 0);
      req_col_s   = 4'($urandom_range(0, 11));
      req_frame_s = 5'($urandom_range(0, 22));
      req_data_s  = $urandom;
      step();
    end
    drain();

`ifdef FRAME_STROBE_COUNT_EN
    // Strobe counter: three good writes and one rejected one, then saturation.
    pulse_reset_mid("rst_cnt");
    send(4'd0, 5'd0, 32'h0000_0001);
    drain();
    send(4'd1, 5'd1, 32'h0000_0002);
    drain();
    send(4'd9, 5'd25, 32'h0000_0003);
    drain();
    send(4'd9, 5'd19, 32'h0000_0004);
    drain();
    chk_val("cnt_a_3", SW'(cnt_a_s), SW'(16'd3));
    force u_dut_a.strobe_count_r = 16'hFFFF;
    #1;
    release u_dut_a.strobe_count_r;
    exp_cnt[0] = 16'hFFFF;
    send(4'd6, 5'd6, 32'h0000_0005);
    drain();
    chk_val("cnt_a_sat", SW'(cnt_a_s), SW'(16'hFFFF));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
